// File: rtl/prog_loader.sv
// Serial program loader: packs synchronised sdi bits (MSB first) into bytes and writes them to
// sequential program addresses while holding the CPU in reset. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld_en_i,
  input  logic              sck_i,
  input  logic              sdi_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [7:0]        csum_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] ld_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sck_prev_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [DATA_W-1:0]      shift_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wr_en_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic                   cpu_hold_q;
  logic                   done_q;
  logic                   ovf_q;

  logic                   ld_s;
  logic                   sck_s;
  logic                   sdi_s;
  logic                   sck_rise;
  logic [DATA_W-1:0]      byte_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [CNT_W-1:0]       bitcnt_d;

  // Pin synchronisers; the previous synced sck value turns level into rise detection
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ld_sync_q  <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      ld_sync_q  <= {ld_sync_q[SYNC_STAGES-2:0], ld_en_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign ld_s     = ld_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  assign byte_d   = {shift_q[DATA_W-2:0], sdi_s};
  assign addr_d   = addr_q + ADDR_W'(1);
  assign bitcnt_d = bitcnt_q + CNT_W'(1);

  // Session FSM; every output is registered and changes only on state transitions
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld_s) begin
            state_q    <= S_LOAD;
            cpu_hold_q <= 1'b1;
            addr_q     <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            ovf_q      <= 1'b0;
          end
        end
        S_LOAD: begin
          // A completing byte wins over a closing session so the last byte is never lost
          if (sck_rise && bitcnt_q == LAST_BIT) begin
            shift_q   <= byte_d;
            bitcnt_q  <= bitcnt_d;
            state_q   <= S_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= byte_d;
          end else begin
            if (sck_rise) begin
              shift_q  <= byte_d;
              bitcnt_q <= bitcnt_d;
            end
            if (!ld_s) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          addr_q   <= addr_d;
          bitcnt_q <= '0;
          if (addr_q == '1) begin
            ovf_q <= 1'b1;
          end
          if (ld_s) begin
            state_q <= S_LOAD;
          end else begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q    <= S_IDLE;
          cpu_hold_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign cpu_hold_o = cpu_hold_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Accumulates the byte on the write strobe, so the sum is visible the cycle after WRITE
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      csum_q <= 8'h00;
    end else if (state_q == S_IDLE && ld_s) begin
      csum_q <= 8'h00;
    end else if (state_q == S_WRITE) begin
      csum_q <= csum_q + 8'(wr_data_q);
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = 8'h00;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: serial pin stimulus with random bit timing, checked against
// a queue-based model of the expected program writes, checksum and overflow flag.
module tb_prog_loader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic          sck;
  logic          sdi;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          cpu_hold_o;
  logic          done_o;
  logic          ovf_o;
  logic [7:0]    csum_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] act_q[$];
  logic [AW+7:0] exp_last;
  int            m_addr;
  logic          m_ovf;
  logic [7:0]    m_sum;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ld_en_i    (ld_en),
    .sck_i      (sck),
    .sdi_i      (sdi),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .ovf_o      (ovf_o),
    .csum_o     (csum_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (cyc > 95000) begin
      $display("FAIL watchdog cycles=%0d limit=95000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  always @(negedge clk) begin
    if (wr_en_o === 1'b1) act_q.push_back({wr_addr_o, wr_data_o});
  end

  function automatic logic [7:0] exp_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_ovf  = 1'b0;
    m_sum  = 8'h00;
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] v);
    exp_last = {AW'(m_addr), v};
    exp_q.push_back(exp_last);
    m_sum = m_sum + v;
    if (m_addr == (1 << AW) - 1) m_ovf = 1'b1;
    m_addr = (m_addr + 1) % (1 << AW);
  endtask

  // One serial bit; when last=1 the write strobe must appear exactly SS+1 cycles after the rise
  task automatic send_bit(input logic b, input logic last);
    int hi;
    int lo;
    @(negedge clk);
    sdi = b;
    sck = 1'b1;
    hi  = $urandom_range(4, 5);
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk);
      checks++;
      if (last && k == SS + 1) begin
        if (wr_en_o !== 1'b1 || {wr_addr_o, wr_data_o} !== exp_last) begin
          failures++;
          $display("FAIL write_strobe k=%0d got en=%0b a/d=%h want en=1 a/d=%h", k, wr_en_o,
                   {wr_addr_o, wr_data_o}, exp_last);
        end
      end else if (wr_en_o !== 1'b0) begin
        failures++;
        $display("FAIL stray_write k=%0d last=%0b got en=%0b want 0", k, last, wr_en_o);
      end
      checks++;
      if (done_o !== 1'b0) begin
        failures++;
        $display("FAIL early_done k=%0d got %0b want 0", k, done_o);
      end
    end
    sck = 1'b0;
    lo  = $urandom_range(4, 5);
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    model_byte(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], i == 0);
  endtask

  task automatic start_session();
    @(negedge clk);
    ld_en = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (cpu_hold_o !== 1'b1) begin
      failures++;
      $display("FAIL start_hold got %0b want 1", cpu_hold_o);
    end
    checks++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL start_ovf got %0b want 0", ovf_o);
    end
    checks++;
    if (csum_o !== 8'h00) begin
      failures++;
      $display("FAIL start_csum got %h want 00", csum_o);
    end
  endtask

  task automatic compare_writes(input string name);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count got %0d want %0d", name, act_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s write[%0d] got a/d=%h want %h", name, i, act_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (csum_o !== exp_csum()) begin
      failures++;
      $display("FAIL %s csum got %h want %h", name, csum_o, exp_csum());
    end
    checks++;
    if (ovf_o !== m_ovf) begin
      failures++;
      $display("FAIL %s ovf got %0b want %0b", name, ovf_o, m_ovf);
    end
  endtask

  task automatic end_session(input string name);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    ld_en = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s done_timeout got done=%0b want 1 within 15 cycles", name, done_o);
    end else begin
      checks++;
      if (cpu_hold_o !== 1'b1) begin
        failures++;
        $display("FAIL %s hold_at_done got %0b want 1", name, cpu_hold_o);
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
        failures++;
        $display("FAIL %s after_done got done=%0b hold=%0b want 0 0", name, done_o, cpu_hold_o);
      end
    end
    compare_writes(name);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, ovf_o, csum_o} !== '0) begin
      failures++;
      $display("FAIL %s outputs got en=%0b a=%h d=%h hold=%0b done=%0b ovf=%0b csum=%h want all 0",
               name, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, ovf_o, csum_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld_en = 1'b0;
    sck   = 1'b0;
    sdi   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");
    start_session();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (cpu_hold_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_resume_hold got %0b want 1", cpu_hold_o);
    end
    send_byte(8'hC3);
    end_session("reset_resume");
  endtask

  task automatic test_two_bytes();
    start_session();
    send_byte(8'hA5);
    send_byte(8'h3C);
    end_session("two_bytes");
    checks++;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (csum_o !== 8'hE1) begin
      failures++;
      $display("FAIL two_bytes_csum_const got %h want e1", csum_o);
    end
`else
    if (csum_o !== 8'h00) begin
      failures++;
      $display("FAIL two_bytes_csum_const got %h want 00", csum_o);
    end
`endif
  endtask

  task automatic test_partial();
    start_session();
    send_byte(8'h12);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    end_session("partial");
  endtask

  task automatic test_coincident_close();
    logic [7:0] v;
    v = 8'h7E;
    start_session();
    model_byte(v);
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    @(negedge clk);
    sdi   = v[0];
    sck   = 1'b1;
    ld_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == SS + 1) begin
        checks++;
        if (wr_en_o !== 1'b1 || {wr_addr_o, wr_data_o} !== exp_last) begin
          failures++;
          $display("FAIL coincident_write got en=%0b a/d=%h want en=1 a/d=%h", wr_en_o,
                   {wr_addr_o, wr_data_o}, exp_last);
        end
      end else if (k == SS + 2) begin
        checks++;
        if (done_o !== 1'b1 || cpu_hold_o !== 1'b1 || wr_en_o !== 1'b0) begin
          failures++;
          $display("FAIL coincident_done got done=%0b hold=%0b en=%0b want 1 1 0", done_o,
                   cpu_hold_o, wr_en_o);
        end
      end else if (k == SS + 3) begin
        checks++;
        if (done_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
          failures++;
          $display("FAIL coincident_idle got done=%0b hold=%0b want 0 0", done_o, cpu_hold_o);
        end
      end
    end
    sck = 1'b0;
    repeat (4) @(negedge clk);
    compare_writes("coincident");
  endtask

  task automatic test_wrap();
    start_session();
    for (int n = 0; n <= (1 << AW); n++) send_byte(8'(n));
    end_session("wrap");
    checks++;
    if (act_q.size() == 0 || act_q[act_q.size()-1] !== {AW'(0), 8'h00}) begin
      failures++;
      $display("FAIL wrap_last got size=%0d want final a/d=0/00", act_q.size());
    end
    checks++;
    if (ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ovf_held got %0b want 1", ovf_o);
    end
    start_session();
    end_session("after_wrap");
  endtask

  task automatic test_random();
    int nb;
    int np;
    for (int s = 0; s < 3; s++) begin
      start_session();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) send_byte(8'($urandom));
      np = $urandom_range(0, 7);
      for (int p = 0; p < np; p++) send_bit(1'($urandom), 1'b0);
      end_session("random");
    end
  endtask

  task automatic test_glitch();
    act_q.delete();
    ld_en = 1'b0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      sdi = 1'($urandom);
      sck = 1'b1;
      @(negedge clk);
      sck = 1'b0;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (wr_en_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
          failures++;
          $display("FAIL glitch got en=%0b hold=%0b want 0 0", wr_en_o, cpu_hold_o);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_writes got %0d want 0", act_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_partial();
    test_coincident_close();
    test_random();
    test_glitch();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
